// File: rtl/fp_accum_pkg.sv
// Shared types, constants and helpers for the fp_accum accumulator.
package fp_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

    localparam logic [31:0] FP_POS_INF = 32'h7F800000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    // Exponent field of zero covers both +/-0 and denormals; the
    // accumulator skips every such term.
    function automatic logic fp_is_zero(input logic [31:0] x);
        return (x[30:23] == 8'h00);
    endfunction

endpackage

// File: rtl/fp_accum_if.sv
// Job, term and result handshake bundle between a producer/consumer and fp_accum.
interface fp_accum_if #(
    parameter int unsigned COUNT_W = 8
) ();

    logic               start;
    logic [COUNT_W-1:0] len;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_sum;
    logic               ovf;
    logic               busy;

    // Producer of jobs/terms and consumer of results.
    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, ovf, busy
    );

    // The accumulator itself.
    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, ovf, busy
    );

endinterface

// File: rtl/fp_accum_fpadd.sv
// Combinational adder for two positive, normalised single-precision values.
// Alignment shifts truncate, and there is no rounding. The exponent is kept
// to 8 bits, so a carry out of 0xFE shows as 0xFF and one out of 0xFF wraps
// to 0x00; the caller relies on both signatures to detect overflow.
module fpadd (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);

    logic        w_a_big;
    logic [30:0] w_big;
    logic [30:0] w_small;
    logic [7:0]  w_exp_diff;
    logic [23:0] w_mant_big;
    logic [23:0] w_mant_small;
    logic [24:0] w_mant_sum;
    logic [7:0]  w_exp_out;
    logic [22:0] w_frac_out;
    logic [1:0]  w_unused_signs;

    assign w_unused_signs = {i_a[31], i_b[31]};

    // Align the smaller operand to the larger, add mantissas, renormalise on carry.
    always_comb begin
        w_a_big      = (i_a[30:0] >= i_b[30:0]);
        w_big        = w_a_big ? i_a[30:0] : i_b[30:0];
        w_small      = w_a_big ? i_b[30:0] : i_a[30:0];
        w_exp_diff   = w_big[30:23] - w_small[30:23];
        w_mant_big   = {1'b1, w_big[22:0]};
        w_mant_small = {1'b1, w_small[22:0]} >> w_exp_diff;
        w_mant_sum   = {1'b0, w_mant_big} + {1'b0, w_mant_small};
        if (w_mant_sum[24]) begin
            w_frac_out = w_mant_sum[23:1];
            w_exp_out  = w_big[30:23] + 8'd1;
        end else begin
            w_frac_out = w_mant_sum[22:0];
            w_exp_out  = w_big[30:23];
        end
        o_y = {1'b0, w_exp_out, w_frac_out};
    end

endmodule

// File: rtl/fp_accum.sv
// Length-prefixed single-precision accumulator. Owns the running sum, feeds it
// back through the combinational fpadd each cycle, and delivers one saturating
// result per job over a ready/valid output.
module fp_accum
    import fp_accum_pkg::*;
#(
    parameter int unsigned COUNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    fp_accum_if.slave   bus
);

    accum_state_t       r_state;
    accum_state_t       w_state_nxt;
    logic [31:0]        r_acc;
    logic [31:0]        w_acc_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               r_acc_empty;
    logic               w_acc_empty_nxt;
    logic [COUNT_W-1:0] r_remaining;
    logic [COUNT_W-1:0] w_remaining_nxt;

    logic [31:0]        w_term;
    logic [31:0]        w_add_sum;
    logic [7:0]         w_sum_exp;
    logic               w_sat;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic               w_unused_sign;

    assign w_unused_sign = bus.in_data[31];
    assign w_term        = {1'b0, bus.in_data[30:0]};

    fpadd u_fpadd (
        .i_a (r_acc),
        .i_b (w_term),
        .o_y (w_add_sum)
    );

    // A result exponent of 0xFF, or one that wrapped below the running
    // exponent, means the true sum no longer fits.
    assign w_sum_exp = w_add_sum[30:23];
    assign w_sat     = (w_sum_exp == FP_EXP_MAX) || (w_sum_exp < r_acc[30:23]);

    // State register and accumulator datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_acc_empty <= 1'b1;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_ovf       <= w_ovf_nxt;
            r_acc_empty <= w_acc_empty_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // Next-state, next-datapath and state-decoded handshake outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_ovf_nxt       = r_ovf;
        w_acc_empty_nxt = r_acc_empty;
        w_remaining_nxt = r_remaining;
        w_in_ready      = (r_state == ACCUM);
        w_out_valid     = (r_state == DONE);
        w_busy          = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_acc_nxt       = '0;
                    w_ovf_nxt       = 1'b0;
                    w_acc_empty_nxt = 1'b1;
                    w_remaining_nxt = bus.len;
                    w_state_nxt     = (bus.len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    w_remaining_nxt = r_remaining - COUNT_W'(1);
                    // Once saturated the sum is frozen; zero/denormal terms
                    // are counted but never touch the sum.
                    if (!r_ovf && !fp_is_zero(w_term)) begin
                        if (r_acc_empty) begin
                            w_acc_nxt       = w_term;
                            w_acc_empty_nxt = 1'b0;
                        end else if (w_sat) begin
                            w_acc_nxt = FP_POS_INF;
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_acc_nxt = w_add_sum;
                        end
                    end
                    if (r_remaining == COUNT_W'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_sum   = r_acc;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_fp_accum.sv
// Scenario bench for fp_accum: expected results are queued when a job is
// started and popped when the accumulator presents its result.
module tb_fp_accum;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fp_accum_if #(.COUNT_W(8)) bus ();

    fp_accum #(.COUNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] term_q[$];
    int          checks = 0;
    int          errors = 0;

    // Pulse start with a length; returns one cycle later (posedge + 1).
    task automatic start_job(input logic [7:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = '0;
    endtask

    // Drive term_q into the DUT; gap idle cycles follow each offered term.
    task automatic feed(input int gap, output int hs, output bit timeout);
        bit fire;
        hs      = 0;
        timeout = 1'b0;
        for (int cyc = 0; cyc < 1000 && term_q.size() > 0; cyc++) begin
            bus.in_valid = (cyc % (gap + 1)) == 0;
            bus.in_data  = term_q[0];
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (fire) begin
                void'(term_q.pop_front());
                hs++;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        if (term_q.size() > 0) begin
            timeout = 1'b1;
            term_q.delete();
        end
    endtask

    // Bounded wait for out_valid.
    task automatic wait_out(output bit got);
        for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        got = (bus.out_valid === 1'b1);
    endtask

    // One-cycle out_ready pulse.
    task automatic accept_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum: got %h expected 00000000", bus.out_sum); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_sum();
        int hs; bit to; exp_t e;
        term_q = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
        exp_q.push_back('{sum: 32'h40400000, ovf: 1'b0});
        start_job(8'd3);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_start_latency: in_ready got %b expected 1", bus.in_ready); end
        feed(0, hs, to);
        checks++; if (to || hs != 3) begin errors++; $display("FAIL basic_handshakes: got %0d (timeout %0d) expected 3", hs, to); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_latency: out_valid got %b expected 1", bus.out_valid); end
        e = exp_q.pop_front();
        checks++; if (bus.out_sum !== e.sum) begin errors++; $display("FAIL basic_sum: got %h expected %h", bus.out_sum, e.sum); end
        checks++; if (bus.ovf !== e.ovf) begin errors++; $display("FAIL basic_ovf: got %b expected %b", bus.ovf, e.ovf); end
        accept_out();
        @(posedge clk); #1;
    endtask

    task automatic test_skip_and_sign();
        int hs; bit to; bit got; exp_t e;
        // zero term is counted but skipped; second term then loads directly
        term_q = '{32'h00000000, 32'h40000000};
        exp_q.push_back('{sum: 32'h40000000, ovf: 1'b0});
        // negative first term is taken as +1.0, then 1.0 + 1.5
        term_q.push_back(32'hBF800000);
        term_q.push_back(32'h3FC00000);
        exp_q.push_back('{sum: 32'h40200000, ovf: 1'b0});
        for (int j = 0; j < 2; j++) begin
            logic [31:0] saved[$];
            saved = term_q;
            term_q = '{saved[0], saved[1]};
            start_job(8'd2);
            feed(0, hs, to);
            term_q = saved[2:$];
            checks++; if (to || hs != 2) begin errors++; $display("FAIL skip_handshakes_%0d: got %0d expected 2", j, hs); end
            wait_out(got);
            e = exp_q.pop_front();
            checks++; if (!got || bus.out_sum !== e.sum) begin errors++; $display("FAIL skip_sum_%0d: got %h (valid %b) expected %h", j, bus.out_sum, got, e.sum); end
            checks++; if (bus.ovf !== e.ovf) begin errors++; $display("FAIL skip_ovf_%0d: got %b expected %b", j, bus.ovf, e.ovf); end
            accept_out();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_len_zero();
        exp_t e;
        exp_q.push_back('{sum: 32'h00000000, ovf: 1'b0});
        start_job(8'd0);
        e = exp_q.pop_front();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL len0_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL len0_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_sum !== e.sum) begin errors++; $display("FAIL len0_sum: got %h expected %h", bus.out_sum, e.sum); end
        checks++; if (bus.ovf !== e.ovf) begin errors++; $display("FAIL len0_ovf: got %b expected %b", bus.ovf, e.ovf); end
        accept_out();
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL len0_back_idle: in_ready %b busy %b expected 0 0", bus.in_ready, bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int hs; bit to; bit got; exp_t e;
        term_q = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000};
        exp_q.push_back('{sum: 32'h7F800000, ovf: 1'b1});
        start_job(8'd3);
        feed(0, hs, to);
        checks++; if (to || hs != 3) begin errors++; $display("FAIL ovf_handshakes: got %0d expected 3", hs); end
        wait_out(got);
        e = exp_q.pop_front();
        checks++; if (!got || bus.out_sum !== e.sum) begin errors++; $display("FAIL ovf_sum: got %h (valid %b) expected %h", bus.out_sum, got, e.sum); end
        checks++; if (bus.ovf !== e.ovf) begin errors++; $display("FAIL ovf_flag: got %b expected %b", bus.ovf, e.ovf); end
        accept_out();
        @(posedge clk); #1;
    endtask

    task automatic test_gapped_backpressure();
        int hs; bit to; bit got; exp_t e;
        // 1 + 2 = 3, 3 + 3 = 6
        for (int g = 0; g < 3; g += 2) begin
            term_q = '{32'h3F800000, 32'h40000000, 32'h40400000};
            exp_q.push_back('{sum: 32'h40C00000, ovf: 1'b0});
            start_job(8'd3);
            feed(g, hs, to);
            checks++; if (to || hs != 3) begin errors++; $display("FAIL gap%0d_handshakes: got %0d expected 3", g, hs); end
            wait_out(got);
            e = exp_q.pop_front();
            checks++; if (!got || bus.out_sum !== e.sum) begin errors++; $display("FAIL gap%0d_sum: got %h (valid %b) expected %h", g, bus.out_sum, got, e.sum); end
            if (g == 2) begin
                // hold the result while start is pulsed; both must be inert
                for (int c = 0; c < 5; c++) begin
                    bus.start = (c % 2) == 0;
                    bus.len   = 8'd5;
                    @(posedge clk); #1;
                    checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.ovf !== e.ovf) begin
                        errors++; $display("FAIL hold_stable_%0d: valid %b sum %h ovf %b expected 1 %h %b", c, bus.out_valid, bus.out_sum, bus.ovf, e.sum, e.ovf);
                    end
                end
                // start coinciding with the output handshake is ignored too
                bus.start = 1'b1;
                accept_out();
                bus.start = 1'b0;
                bus.len   = '0;
                checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: busy %b out_valid %b expected 0 0", bus.busy, bus.out_valid); end
                @(posedge clk); #1;
                checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL start_ignored: busy %b in_ready %b expected 0 0", bus.busy, bus.in_ready); end
            end else begin
                accept_out();
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int hs; bit to; bit got; exp_t e;
        term_q = '{32'h40000000, 32'h40400000};
        start_job(8'd4);
        feed(0, hs, to);
        checks++; if (to || hs != 2 || bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_partial: handshakes %0d busy %b expected 2 1", hs, bus.busy); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: in_ready %b out_valid %b busy %b expected 0 0 0", bus.in_ready, bus.out_valid, bus.busy);
        end
        checks++; if (bus.out_sum !== 32'h0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL midrst_data: sum %h ovf %b expected 00000000 0", bus.out_sum, bus.ovf); end
        reset = 1'b1;
        @(posedge clk); #1;
        term_q = '{32'h40000000};
        exp_q.push_back('{sum: 32'h40000000, ovf: 1'b0});
        start_job(8'd1);
        feed(0, hs, to);
        wait_out(got);
        e = exp_q.pop_front();
        checks++; if (!got || bus.out_sum !== e.sum || bus.ovf !== e.ovf) begin
            errors++; $display("FAIL midrst_new_job: sum %h ovf %b (valid %b) expected %h %b", bus.out_sum, bus.ovf, got, e.sum, e.ovf);
        end
        accept_out();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_skip_and_sign();
        test_len_zero();
        test_overflow();
        test_gapped_backpressure();
        test_reset_mid_job();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_accum.md
# fp_accum

Sequential single-precision accumulator that sums a length-prefixed stream of positive floats. It sits directly downstream of the combinational `fpadd` adder, which it instantiates: it owns the running sum, feeds it back into the adder every cycle, and delivers one final sum per job. It has ready/valid handshakes on both input and output, and reports overflow by saturating the sum.

## Interface
- `COUNT_W`, default 8: width of the term counter; a job may hold up to 2^COUNT_W−1 terms.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `start`  in  1  begin a job; sampled only in IDLE.
- `len`  in  COUNT_W  number of terms in the job; sampled with `start`.
- `in_valid`  in  1  `in_data` holds a term.
- `in_ready`  out  1  accumulator accepts a term this cycle.
- `in_data`  in  32  IEEE-754 single term; bit 31 is ignored (treated as 0).
- `out_valid`  out  1  `out_sum` and `ovf` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  32  final sum; bit 31 is always 0.
- `ovf`  out  1  the sum saturated during the job.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `start`=1 and `len`≠0 → ACCUM; clear `acc` and `ovf`, set `acc_empty`=1, set `remaining`=`len`.
  - `start`=1 and `len`=0 → DONE with `acc`=0 and `ovf`=0.
- ACCUM: `in_ready`=1. Each handshake (`in_valid` & `in_ready`) consumes one term and decrements `remaining`.
  - Term with exponent field 0 (zero or denormal): skipped. `acc` is unchanged, but the term still counts.
  - First non-skipped term (`acc_empty`=1): loaded directly, `acc` = {0, `in_data[30:0]`}. The adder cannot represent 0 because of its implicit leading 1, so the first term bypasses it.
  - Later terms: `acc` = `fpadd`(`acc`, {0, `in_data[30:0]`}). Truncation only, no rounding, as the adder does.
  - Overflow: if the adder result exponent is 0xFF, or is less than the `acc` exponent (wrap), then `acc` = 0x7F800000 and `ovf`=1. Remaining terms are consumed but `acc` stays saturated.
  - Handshake with `remaining`=1 → DONE.
- DONE: `out_valid`=1, `out_sum`=`acc`. On `out_valid` & `out_ready` → IDLE. `start` is ignored outside IDLE.
- Input with exponent field 0xFF is summed arithmetically without special-case handling; callers must not send it.
- Reset low in any state → IDLE next edge; the partial sum is discarded.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_sum`=0, `ovf`=0, `busy`=0, state IDLE.
- Throughput: one term per cycle; the adder is combinational within the cycle.
- Latency: `start` → `in_ready` high on the next cycle. Last term handshake → `out_valid` high on the next cycle.
- `out_sum` and `ovf` are registered and remain stable while `out_valid`=1 and `out_ready`=0.
- Minimum one IDLE cycle between jobs. A `start` in the cycle of the output handshake is ignored.
- `in_ready` is a pure function of state (no combinational path from `in_valid`). `out_valid` is likewise a function of state only.

## Structure
- Package `fp_accum_pkg`:
  - state enum `accum_state_t` {IDLE, ACCUM, DONE};
  - constants `FP_POS_INF`=32'h7F800000, `FP_EXP_MAX`=8'hFF;
  - helper function `fp_is_zero(logic [31:0])`.
- One sub-module instance: `fpadd`, in the feedback path `acc` → `fpadd.a`, term → `fpadd.b`.
- The FSM, counter, and overflow/skip logic live in `fp_accum` itself.

## Test plan
- `len`=3, terms 0x3F800000 ×3 → `out_sum`=0x40400000 (3.0), `ovf`=0. `out_valid` is high the cycle after the 3rd handshake.
- `len`=2, terms {0x00000000, 0x40000000} → 0x40000000. Terms {0xBF800000, 0x3FC00000} → 0x40200000 (2.5; sign ignored).
- `len`=0 with `start` → `out_valid` on the next cycle, `out_sum`=0x00000000, `ovf`=0, and `in_ready` never asserts.
- `len`=3, terms {0x7F7FFFFF, 0x7F7FFFFF, 0x3F800000} → `ovf`=1, `out_sum`=0x7F800000, and all 3 terms are handshaken.
- `in_valid` gapped (1 of 3 cycles), then `out_ready` held low 5 cycles → the sum equals the ungapped result, and `out_sum` is stable over those 5 cycles. `start` pulsed during DONE is ignored.
- Reset driven low mid-ACCUM after 2 of 4 terms → next cycle IDLE with all outputs at reset values. A new job (`len`=1, 0x40000000) then returns 0x40000000.
